// File: rtl/dma_utils_pkg.sv
// Shared AXI4 types for the DMA subsystem: request/response bundles,
// burst/response encodings and the responder FSM state type.
package dma_utils_pkg;

    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_DATA
    } resp_fsm_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   awid;
        logic [AXI_ADDR_WIDTH-1:0] awaddr;
        logic [7:0]                awlen;
        logic [2:0]                awsize;
        logic [1:0]                awburst;
        logic                      awvalid;
        logic [AXI_DATA_WIDTH-1:0] wdata;
        logic [AXI_STRB_WIDTH-1:0] wstrb;
        logic                      wlast;
        logic                      wvalid;
        logic                      bready;
        logic [AXI_ID_WIDTH-1:0]   arid;
        logic [AXI_ADDR_WIDTH-1:0] araddr;
        logic [7:0]                arlen;
        logic [2:0]                arsize;
        logic [1:0]                arburst;
        logic                      arvalid;
        logic                      rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                      awready;
        logic                      wready;
        logic [AXI_ID_WIDTH-1:0]   bid;
        logic [1:0]                bresp;
        logic                      buser;
        logic                      bvalid;
        logic                      arready;
        logic [AXI_ID_WIDTH-1:0]   rid;
        logic [AXI_DATA_WIDTH-1:0] rdata;
        logic [1:0]                rresp;
        logic                      rlast;
        logic                      ruser;
        logic                      rvalid;
    } s_axi_miso_t;

endpackage

// File: rtl/dma_axi_addr_gen.sv
// Combinational AXI address step, memory word index and error flag.
// Ports: addr_i/size_i/burst_i in; next_addr_o, word_idx_o, err_o out.
module dma_axi_addr_gen
    import dma_utils_pkg::*;
#(
    parameter int                        MEM_WORDS = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int                        DATA_W    = AXI_DATA_WIDTH,
    localparam int                       IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]                size_i,
    input  logic [1:0]                burst_i,
    output logic [AXI_ADDR_WIDTH-1:0] next_addr_o,
    output logic [IDX_W-1:0]          word_idx_o,
    output logic                      err_o
);

    localparam int AW    = AXI_ADDR_WIDTH;
    localparam int SHIFT = $clog2(DATA_W / 8);

    logic [AW-1:0] offs;
    logic [AW-1:0] word_full;
    logic          oob;
    logic          size_err;
    logic          burst_err;

    // Low address bits are dropped, so unaligned starts align down.
    assign offs       = addr_i - BASE_ADDR;
    assign word_full  = offs >> SHIFT;
    assign word_idx_o = word_full[IDX_W-1:0];

    assign oob = (addr_i < BASE_ADDR)
               || (word_full >= AW'(MEM_WORDS));
    assign size_err  = (size_i > 3'(SHIFT));
    assign burst_err = (burst_i != FIXED) && (burst_i != INCR);
    assign err_o     = oob || size_err || burst_err;

    assign next_addr_o = (burst_i == INCR)
                       ? addr_i + (AW'(1) << size_i)
                       : addr_i;

endmodule

// File: rtl/dma_axi_mem_responder.sv
// AXI4 slave backed by a flop-array memory; one transaction at a time.
// Ports: clk, rst (async high), axi_mosi_i, axi_miso_o, busy_o.
module dma_axi_mem_responder
    import dma_utils_pkg::*;
#(
    parameter int                        MEM_WORDS = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int                        DATA_W    = AXI_DATA_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  s_axi_mosi_t axi_mosi_i,
    output s_axi_miso_t axi_miso_o,
    output logic        busy_o
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int STRB_W = DATA_W / 8;
    localparam int AW     = AXI_ADDR_WIDTH;
    localparam int IW     = AXI_ID_WIDTH;

    resp_fsm_t          state_q, state_d;
    logic               last_wr_q;
    logic [IW-1:0]      id_q;
    logic [AW-1:0]      addr_q;
    logic [7:0]         len_q;
    logic [2:0]         size_q;
    logic [1:0]         burst_q;
    logic [8:0]         beat_q;
    logic               err_q;
    logic               rvalid_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [1:0]         rresp_q;
    logic               rlast_q;

    logic [DATA_W-1:0]  mem_q [MEM_WORDS];

    logic               grant_wr;
    logic               grant_rd;
    logic               aw_hs;
    logic               ar_hs;
    logic               wr_fire;
    logic               rd_hs;
    logic               rd_adv;
    logic               rd_done;

    logic [AW-1:0]      ag_addr;
    logic [2:0]         ag_size;
    logic [1:0]         ag_burst;
    logic [AW-1:0]      ag_next;
    logic [IDX_W-1:0]   ag_idx;
    logic               ag_err;
    logic [DATA_W-1:0]  rd_word;
    logic               len_err;

    // Round-robin between AW and AR only matters when both are valid.
    assign grant_wr = axi_mosi_i.awvalid
                    && (!axi_mosi_i.arvalid || !last_wr_q);
    assign grant_rd = axi_mosi_i.arvalid
                    && (!axi_mosi_i.awvalid || last_wr_q);

    assign aw_hs   = (state_q == IDLE) && grant_wr;
    assign ar_hs   = (state_q == IDLE) && grant_rd;
    assign wr_fire = (state_q == WR_DATA) && axi_mosi_i.wvalid;
    assign rd_hs   = (state_q == RD_DATA) && rvalid_q
                   && axi_mosi_i.rready;
    assign rd_adv  = rd_hs && !rlast_q;
    assign rd_done = rd_hs && rlast_q;

    // In IDLE the generator looks at the AR request so the first read
    // beat can be fetched in the handshake cycle.
    always_comb begin
        ag_addr  = addr_q;
        ag_size  = size_q;
        ag_burst = burst_q;
        if (state_q == IDLE) begin
            ag_addr  = axi_mosi_i.araddr;
            ag_size  = axi_mosi_i.arsize;
            ag_burst = axi_mosi_i.arburst;
        end
    end

    dma_axi_addr_gen #(
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE_ADDR),
        .DATA_W    (DATA_W)
    ) u_addr_gen (
        .addr_i      (ag_addr),
        .size_i      (ag_size),
        .burst_i     (ag_burst),
        .next_addr_o (ag_next),
        .word_idx_o  (ag_idx),
        .err_o       (ag_err)
    );

    assign rd_word = ag_err ? '0 : mem_q[ag_idx];
    assign len_err = axi_mosi_i.wlast && (beat_q != {1'b0, len_q});

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    state_d = WR_DATA;
                end else if (ar_hs) begin
                    state_d = RD_DATA;
                end
            end
            WR_DATA: begin
                if (wr_fire && axi_mosi_i.wlast) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi_mosi_i.bready) begin
                    state_d = IDLE;
                end
            end
            RD_DATA: begin
                if (rd_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            rlast_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                last_wr_q <= 1'b1;
                id_q      <= axi_mosi_i.awid;
                addr_q    <= axi_mosi_i.awaddr;
                len_q     <= axi_mosi_i.awlen;
                size_q    <= axi_mosi_i.awsize;
                burst_q   <= axi_mosi_i.awburst;
                beat_q    <= '0;
                err_q     <= 1'b0;
            end else if (ar_hs) begin
                last_wr_q <= 1'b0;
                id_q      <= axi_mosi_i.arid;
                addr_q    <= ag_next;
                len_q     <= axi_mosi_i.arlen;
                size_q    <= axi_mosi_i.arsize;
                burst_q   <= axi_mosi_i.arburst;
                beat_q    <= 9'd1;
                rvalid_q  <= 1'b1;
                rdata_q   <= rd_word;
                rresp_q   <= ag_err ? SLVERR : OKAY;
                rlast_q   <= (axi_mosi_i.arlen == 8'd0);
            end else if (wr_fire) begin
                addr_q <= ag_next;
                beat_q <= beat_q + 9'd1;
                if (ag_err || len_err) begin
                    err_q <= 1'b1;
                end
            end else if (state_q == WR_RESP && axi_mosi_i.bready) begin
                err_q <= 1'b0;
            end else if (rd_adv) begin
                addr_q  <= ag_next;
                beat_q  <= beat_q + 9'd1;
                rdata_q <= rd_word;
                rresp_q <= ag_err ? SLVERR : OKAY;
                rlast_q <= (beat_q == {1'b0, len_q});
            end else if (rd_done) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire && !ag_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_mosi_i.wstrb[b]) begin
                    mem_q[ag_idx][8*b +: 8] <= axi_mosi_i.wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        axi_miso_o         = '0;
        axi_miso_o.awready = aw_hs;
        axi_miso_o.arready = ar_hs;
        axi_miso_o.wready  = (state_q == WR_DATA);
        axi_miso_o.bvalid  = (state_q == WR_RESP);
        axi_miso_o.bid     = id_q;
        axi_miso_o.bresp   = err_q ? SLVERR : OKAY;
        axi_miso_o.rvalid  = rvalid_q;
        axi_miso_o.rid     = id_q;
        axi_miso_o.rdata   = rdata_q;
        axi_miso_o.rresp   = rresp_q;
        axi_miso_o.rlast   = rlast_q;
    end

    assign busy_o = (state_q != IDLE);

endmodule
